// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder-tree operand loader: default widths and FSM state type.
package adder_tree_pkg;

  localparam int unsigned ADDER_WIDTH_DEFAULT = 21;
  localparam int unsigned NUM_LEAVES          = 8;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage : adder_tree_pkg

// File: rtl/adder_tree_slot_reg.sv
// One operand slot: W-bit register with synchronous reset, clear and write-enable.
module adder_tree_slot_reg #(
  parameter int unsigned W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Clear wins over write so zero-padding cannot be overridden.
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (we_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule : adder_tree_slot_reg

// File: rtl/adder_tree_loader.sv
// Collects operand words into 8-wide groups for the adder-tree input registers.
// Optional short-group zero padding is enabled by defining ADDER_LOADER_ZERO_PAD_EN.
module adder_tree_loader #(
  parameter int unsigned ADDER_WIDTH = adder_tree_pkg::ADDER_WIDTH_DEFAULT,
  parameter int unsigned NUM_LEAVES  = adder_tree_pkg::NUM_LEAVES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [ADDER_WIDTH-1:0]          in_data,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LEAVES*ADDER_WIDTH-1:0] out_ops,
  output logic [3:0]                      out_count,
  output logic [7:0]                      group_id
);

  import adder_tree_pkg::*;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned GID_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEAVES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GID_W-1:0] gid_q, gid_d;

  logic                  accept_c;
  logic                  close_c;
  logic [NUM_LEAVES-1:0] we_c;
  logic [NUM_LEAVES-1:0] clr_c;

  assign accept_c = in_valid && (state_q == FILL);

`ifdef ADDER_LOADER_ZERO_PAD_EN
  assign close_c = accept_c && ((idx_q == LAST_IDX) || in_last);
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign close_c        = accept_c && (idx_q == LAST_IDX);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      count_q <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      gid_q   <= gid_d;
    end
  end

  // Next-state, slot write enables and pad clears.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    gid_d   = gid_q;
    we_c    = '0;
    clr_c   = '0;
    unique case (state_q)
      FILL: begin
        if (accept_c) begin
          we_c[idx_q] = 1'b1;
          idx_d       = idx_q + IDX_W'(1);
          if (close_c) begin
            state_d = HOLD;
            idx_d   = '0;
            count_d = CNT_W'(idx_q) + CNT_W'(1);
`ifdef ADDER_LOADER_ZERO_PAD_EN
            for (int unsigned i = 0; i < NUM_LEAVES; i++) begin
              if (IDX_W'(i) > idx_q) begin
                clr_c[i] = 1'b1;
              end
            end
`endif
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          gid_d   = gid_q + GID_W'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

  for (genvar g = 0; g < NUM_LEAVES; g++) begin : g_slot
    adder_tree_slot_reg #(
      .W(ADDER_WIDTH)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .we_i (we_c[g]),
      .clr_i(clr_c[g]),
      .d_i  (in_data),
      .q_o  (out_ops[g*ADDER_WIDTH +: ADDER_WIDTH])
    );
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out_count = count_q;
  assign group_id  = gid_q;

endmodule : adder_tree_loader

// File: tb/tb_adder_tree_loader.sv
// Directed self-checking bench for adder_tree_loader (default build; pad checks
// switch on with ADDER_LOADER_ZERO_PAD_EN).
module tb_adder_tree_loader;

  localparam int unsigned W = 21;
  localparam int unsigned N = 8;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_ops;
  logic [3:0]     out_count;
  logic [7:0]     group_id;

  int checks;
  int failures;

  adder_tree_loader #(
    .ADDER_WIDTH(W),
    .NUM_LEAVES (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ops  (out_ops),
    .out_count(out_count),
    .group_id (group_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slot(input int s);
    logic [W-1:0] v;
    v = out_ops[s*W +: W];
    return 32'(v);
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Feeds n consecutive words base..base+n-1 back-to-back, then drops in_valid.
  task automatic feed(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = W'(base + i);
      in_last  = 1'b0;
      tick();
    end
    in_valid = 1'b0;
  endtask

  int k;
  int g;
  logic v;

  initial begin
    checks   = 0;
    failures = 0;
    in_data  = '0;
    k        = 0;
    g        = 0;
    do_reset();

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_group_id", 32'(group_id), 32'd0);
    chk("rst_out_ops_zero", 32'(|out_ops), 32'd0);

    // First group: words 1..8, valid exactly one cycle after the 8th accept.
    feed(1, 7);
    chk("g0_not_valid_after7", 32'(out_valid), 32'd0);
    feed(8, 1);
    chk("g0_out_valid", 32'(out_valid), 32'd1);
    chk("g0_in_ready", 32'(in_ready), 32'd0);
    for (int s = 0; s < 8; s++) chk($sformatf("g0_slot%0d", s), slot(s), 32'(s + 1));
    chk("g0_out_count", 32'(out_count), 32'd8);
    chk("g0_group_id", 32'(group_id), 32'd0);

    // Stall in HOLD with upstream still pushing.
    in_valid  = 1'b1;
    in_data   = W'(32'h55);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_slot0", slot(0), 32'd1);
      chk("hold_slot7", slot(7), 32'd8);
      chk("hold_count", 32'(out_count), 32'd8);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("xfer_out_valid", 32'(out_valid), 32'd0);
    chk("xfer_in_ready", 32'(in_ready), 32'd1);
    chk("xfer_group_id", 32'(group_id), 32'd1);

    // Random in_valid over three groups, out_ready held high.
    do_reset();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && g < 3; cyc++) begin
      if (out_valid) begin
        for (int s = 0; s < 8; s++) chk($sformatf("rnd_g%0d_slot%0d", g, s), slot(s), 32'(100 + g*8 + s));
        chk("rnd_group_id", 32'(group_id), 32'(g));
        g++;
      end
      v        = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = in_ready ? W'(100 + k) : W'(32'h1ABCDE);
      if (v && in_ready) k++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rnd_groups_seen", 32'(g), 32'd3);
    chk("rnd_words_accepted", 32'(k), 32'd24);

    // Short group terminated by in_last.
    feed(0, 0);
    in_valid = 1'b1; in_data = W'(32'h1FFFFF); tick();
    in_data  = W'(32'h000001); tick();
    in_data  = W'(32'h000002); in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
`ifdef ADDER_LOADER_ZERO_PAD_EN
    chk("pad_out_valid", 32'(out_valid), 32'd1);
    chk("pad_slot0", slot(0), 32'h1FFFFF);
    chk("pad_slot1", slot(1), 32'h1);
    chk("pad_slot2", slot(2), 32'h2);
    for (int s = 3; s < 8; s++) chk($sformatf("pad_slot%0d", s), slot(s), 32'd0);
    chk("pad_out_count", 32'(out_count), 32'd3);
`else
    chk("nopad_still_filling", 32'(out_valid), 32'd0);
    feed(300, 5);
    chk("nopad_out_valid", 32'(out_valid), 32'd1);
    chk("nopad_slot0", slot(0), 32'h1FFFFF);
    chk("nopad_slot2", slot(2), 32'h2);
    chk("nopad_slot7", slot(7), 32'd304);
    chk("nopad_out_count", 32'(out_count), 32'd8);
`endif
    chk("short_group_id", 32'(group_id), 32'd3);

    // Reset mid-fill discards partial data, and beats a simultaneous accept.
    do_reset();
    feed(50, 4);
    in_valid = 1'b1;
    in_data  = W'(32'h777);
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_ops_zero", 32'(|out_ops), 32'd0);
    feed(200, 7);
    chk("post_rst_not_valid", 32'(out_valid), 32'd0);
    feed(207, 1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);
    for (int s = 0; s < 8; s++) chk($sformatf("post_rst_slot%0d", s), slot(s), 32'(200 + s));
    chk("post_rst_group_id", 32'(group_id), 32'd0);

    // group_id wrap: 257 transfers in total.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      feed(n, 8);
      chk($sformatf("wrap_valid_%0d", n), 32'(out_valid), 32'd1);
      chk($sformatf("wrap_gid_%0d", n), 32'(group_id), 32'(n % 256));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("wrap_final_gid", 32'(group_id), 32'd1);
    chk("wrap_final_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_adder_tree_loader

// File: doc/adder_tree_loader.md
ADDER_TREE_LOADER -- requirements
Module: adder_tree_loader

Interface
REQ-001 Parameter ADDER_WIDTH, default 21: width of each operand word.
REQ-002 Parameter NUM_LEAVES, default 8: operands per group, fixed to 8 for this block.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_data  input  ADDER_WIDTH  upstream operand word.
REQ-007 in_last  input  1  final word of a short group; used only when ADDER_LOADER_ZERO_PAD_EN is defined.
REQ-008 in_ready  output  1  loader accepts a word this cycle.
REQ-009 out_valid  output  1  a full 8-operand group is presented.
REQ-010 out_ready  input  1  the adder-tree input registers take the group this cycle.
REQ-011 out_ops  output  8*ADDER_WIDTH  group; slot i at bits [i*ADDER_WIDTH +: ADDER_WIDTH], slot 0 = isum0_0_0_0 lane, slot 7 = isum0_1_1_1 lane.
REQ-012 out_count  output  4  number of real (non-padded) operands in the group, range 1..8.
REQ-013 group_id  output  8  sequence number of the presented group.

Function
REQ-014 The FSM SHALL have two states: FILL and HOLD.
REQ-015 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0; in HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-016 A word is accepted on a cycle where in_valid and in_ready are both 1; it SHALL be written to slot idx, and idx (3 bits) SHALL increment.
REQ-017 Acceptance with idx==7 SHALL move the FSM to HOLD on the next cycle, with out_count=8; idx SHALL wrap to 0.
REQ-018 A transfer occurs on a cycle where out_valid and out_ready are both 1; the FSM SHALL then move to FILL, and group_id SHALL increment modulo 256.
REQ-019 out_ops, out_count and group_id SHALL remain stable throughout HOLD.
REQ-020 Latency from acceptance of the 8th word to out_valid=1 SHALL be exactly 1 cycle.
REQ-021 Throughput SHALL be 1 group per 9 cycles minimum: 8 fill cycles plus 1 hold cycle with out_ready=1.
REQ-022 out_ready SHALL be ignored in FILL, and in_valid SHALL be ignored in HOLD; no data is lost or duplicated.
REQ-023 Operands SHALL pass through unmodified; there is no arithmetic, sign extension or truncation.

Reset
REQ-024 On rst=1 at posedge clk, the block SHALL take: state=FILL, idx=0, out_ops=0, out_count=0, group_id=0, out_valid=0.
REQ-025 rst SHALL take priority over any simultaneous handshake.
REQ-026 A partially filled group or a held group SHALL be discarded by reset.
REQ-027 in_ready SHALL be 1 on the first cycle after reset release.

Configuration
REQ-028 Macro ADDER_LOADER_ZERO_PAD_EN, when defined: acceptance with in_last=1 at idx<7 SHALL clear slots idx+1..7 to zero, set out_count=idx+1, enter HOLD and reset idx to 0.
REQ-029 ADDER_LOADER_ZERO_PAD_EN, when defined: in_last=1 at idx==7 SHALL behave as a normal full group.
REQ-030 Without ADDER_LOADER_ZERO_PAD_EN: in_last SHALL be ignored, groups are always 8 words, and out_count is constant 8 after the first group.

Structure
REQ-031 A shared package adder_tree_pkg SHALL hold ADDER_WIDTH_DEFAULT=21, NUM_LEAVES=8, and the FSM state enum typedef.
REQ-032 One sub-module, adder_tree_slot_reg, SHALL be used: an ADDER_WIDTH register with write-enable and clear, instantiated 8 times.

Verification
REQ-033 Reset, then 8 accepted words 1..8 back-to-back -> out_valid=1 on the next cycle; slots 0..7 = 1..8; out_count=8; group_id=0.
REQ-034 out_ready held 0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, and out_ops is unchanged; then out_ready=1 -> FILL, group_id=1.
REQ-035 in_valid toggled randomly over 3 groups with out_ready=1 -> all 24 words appear in order; group_id sequence 0,1,2.
REQ-036 With ADDER_LOADER_ZERO_PAD_EN: words 0x1FFFFF, 0x000001, 0x000002 with in_last on the third word -> slots 3..7 = 0 and out_count=3.
REQ-037 rst asserted after 4 words are accepted -> no out_valid; the next 8 words form a clean group with group_id=0.
REQ-038 257 groups transferred -> group_id wraps 255 -> 0.
